// File: rtl/sseg4_decoder.sv
// Receive-side decoder for a multiplexed 4-digit active-low seven-segment bus.
// Waits for each digit dwell to settle, then turns the lit pattern back into a nibble and flags.
module sseg4_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        dp,
    output logic [15:0] data,
    output logic [3:0]  digit_valid,
    output logic [3:0]  blank,
    output logic [3:0]  minus,
    output logic [3:0]  dp_out,
    output logic        frame_done,
    output logic        err,
    output logic        stale
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // Returns {hit, nibble}; p is active-high in gfedcba order.
    function automatic logic [4:0] hex_decode(input logic [6:0] p);
        logic [4:0] r;
        r = 5'h00;
        case (p)
            7'h3F: r = 5'h10;
            7'h06: r = 5'h11;
            7'h5B: r = 5'h12;
            7'h4F: r = 5'h13;
            7'h66: r = 5'h14;
            7'h6D: r = 5'h15;
            7'h7D: r = 5'h16;
            7'h07: r = 5'h17;
            7'h7F: r = 5'h18;
            7'h6F: r = 5'h19;
            7'h77: r = 5'h1A;
            7'h7C: r = 5'h1B;
            7'h39: r = 5'h1C;
            7'h5E: r = 5'h1D;
            7'h79: r = 5'h1E;
            7'h71: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Input sample {an, seg, dp} and the sample from the cycle before.
    logic [11:0]      r_q, r_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic [3:0]       seen_q, seen_d;
    logic [3:0]       nib_q [4];
    logic [3:0]       nib_d [4];
    logic [3:0]       vld_q, vld_d;
    logic [3:0]       blank_q, blank_d;
    logic [3:0]       minus_q, minus_d;
    logic [3:0]       dpo_q, dpo_d;
    logic             frame_q, frame_d;
    logic             err_q, err_d;
    logic             stale_q, stale_d;

    logic [3:0] an_r;
    logic [6:0] seg_r;
    logic       dp_r;
    logic [6:0] pat;
    logic [4:0] dec;
    logic       hit, is_blank, is_minus, bad;
    logic       one_low, same, capture, timeout_fire;
    logic [3:0] dig_sel, seen_or;

    assign an_r  = r_q[11:8];
    assign seg_r = r_q[7:1];
    assign dp_r  = r_q[0];
    assign pat   = ~seg_r;
    assign dec   = hex_decode(pat);
    assign hit      = dec[4];
    assign is_blank = (pat == 7'h00);
    assign is_minus = (pat == 7'h40);
    assign bad      = !hit && !is_blank && !is_minus;

    always_comb begin
        one_low = 1'b0;
        case (an_r)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default: one_low = 1'b0;
        endcase
    end

    assign same = (r_q == r_prev_q);

    // Idle anodes park the counter at 0 so a dwell always starts counting from a change.
    always_comb begin
        cnt_d = cnt_q;
        if (!one_low)
            cnt_d = '0;
        else if (!same)
            cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
    end

    assign capture      = one_low && same && (cnt_q == CNT_PRE);
    assign timeout_fire = !capture && (tcnt_q == TO_LAST);
    assign dig_sel      = capture ? ~an_r : 4'b0000;
    assign seen_or      = seen_q | dig_sel;

    always_comb begin
        tcnt_d = tcnt_q;
        if (capture)
            tcnt_d = '0;
        else if (tcnt_q != TO_MAX)
            tcnt_d = tcnt_q + TO_W'(1);
    end

    always_comb begin
        frame_d = capture && (&seen_or);
        err_d   = capture && bad;
        seen_d  = seen_or;
        if (timeout_fire || frame_d)
            seen_d = 4'b0000;
        stale_d = stale_q;
        if (capture)
            stale_d = 1'b0;
        else if (timeout_fire)
            stale_d = 1'b1;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign nib_d[gi]   = (dig_sel[gi] && hit) ? dec[3:0] : nib_q[gi];
            assign vld_d[gi]   = dig_sel[gi] ? hit : (timeout_fire ? 1'b0 : vld_q[gi]);
            assign blank_d[gi] = dig_sel[gi] ? is_blank : blank_q[gi];
            assign minus_d[gi] = dig_sel[gi] ? is_minus : minus_q[gi];
            assign dpo_d[gi]   = dig_sel[gi] ? ~dp_r : dpo_q[gi];
            assign data[4*gi +: 4] = nib_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q      <= '0;
            r_prev_q <= '0;
            cnt_q    <= '0;
            tcnt_q   <= '0;
            seen_q   <= '0;
            for (int i = 0; i < 4; i++)
                nib_q[i] <= '0;
            vld_q    <= '0;
            blank_q  <= '0;
            minus_q  <= '0;
            dpo_q    <= '0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
            stale_q  <= 1'b0;
        end else begin
            r_q      <= {an, seg, dp};
            r_prev_q <= r_q;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            seen_q   <= seen_d;
            for (int i = 0; i < 4; i++)
                nib_q[i] <= nib_d[i];
            vld_q    <= vld_d;
            blank_q  <= blank_d;
            minus_q  <= minus_d;
            dpo_q    <= dpo_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
            stale_q  <= stale_d;
        end
    end

    assign digit_valid = vld_q;
    assign blank       = blank_q;
    assign minus       = minus_q;
    assign dp_out      = dpo_q;
    assign frame_done  = frame_q;
    assign err         = err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_sseg4_decoder.sv
// Bench for sseg4_decoder: dwell table with an expected-result queue, plus
// hand sequences for capture latency, timeout and reset mid-dwell.
module tb_sseg4_decoder;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] data;
    logic [3:0]  digit_valid, blank, minus, dp_out;
    logic        frame_done, err, stale;

    always #5 clk = ~clk;

    sseg4_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .an(an), .seg(seg), .dp(dp),
        .data(data), .digit_valid(digit_valid), .blank(blank), .minus(minus),
        .dp_out(dp_out), .frame_done(frame_done), .err(err), .stale(stale)
    );

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  p;
        logic        dpon;
        int          hold;
        logic [15:0] data;
        logic [3:0]  vld;
        logic [3:0]  blk;
        logic [3:0]  mns;
        logic [3:0]  dpo;
        int          frames;
        int          errs;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int frame_cnt = 0;
    int err_cnt = 0;
    vec_t vecs [17];
    vec_t exp_q [$];

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_done) frame_cnt <= frame_cnt + 1;
        if (err)        err_cnt   <= err_cnt + 1;
    end

    function automatic vec_t mk(input logic [3:0] a, input logic [6:0] p, input logic dpon,
                                input int hold, input logic [15:0] d, input logic [3:0] v,
                                input logic [3:0] b, input logic [3:0] m, input logic [3:0] o,
                                input int f, input int e);
        vec_t t;
        t.an = a; t.p = p; t.dpon = dpon; t.hold = hold; t.data = d; t.vld = v;
        t.blk = b; t.mns = m; t.dpo = o; t.frames = f; t.errs = e;
        return t;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] p, input logic dpon);
        an  = a;
        seg = ~p;
        dp  = ~dpon;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    initial begin
        int f0, e0;
        vec_t e;

        //          an       p      dp hold data      vld      blk      mns      dpo     f  e
        vecs[0]  = mk(4'b1110, 7'h71, 0, 8, 16'h000F, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vecs[1]  = mk(4'b1101, 7'h5B, 0, 8, 16'h002F, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vecs[2]  = mk(4'b1011, 7'h77, 1, 8, 16'h0A2F, 4'b0111, 4'b0000, 4'b0000, 4'b0100, 0, 0);
        vecs[3]  = mk(4'b0111, 7'h06, 0, 8, 16'h1A2F, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 0);
        vecs[4]  = mk(4'b1110, 7'h71, 0, 8, 16'h1A2F, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 0, 0);
        vecs[5]  = mk(4'b1101, 7'h5B, 0, 8, 16'h1A2F, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 0, 0);
        vecs[6]  = mk(4'b1011, 7'h77, 1, 8, 16'h1A2F, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 0, 0);
        vecs[7]  = mk(4'b0111, 7'h06, 0, 8, 16'h1A2F, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 0);
        vecs[8]  = mk(4'b1101, 7'h3F, 0, 3, 16'h1A2F, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 0, 0);
        vecs[9]  = mk(4'b1100, 7'h06, 0, 10, 16'h1A2F, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 0, 0);
        vecs[10] = mk(4'b0111, 7'h40, 0, 8, 16'h1A2F, 4'b0111, 4'b0000, 4'b1000, 4'b0100, 0, 0);
        vecs[11] = mk(4'b0111, 7'h00, 0, 8, 16'h1A2F, 4'b0111, 4'b1000, 4'b0000, 4'b0100, 0, 0);
        vecs[12] = mk(4'b0111, 7'h55, 1, 8, 16'h1A2F, 4'b0111, 4'b0000, 4'b0000, 4'b1100, 0, 1);
        vecs[13] = mk(4'b0111, 7'h7C, 0, 8, 16'hBA2F, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 0, 0);
        vecs[14] = mk(4'b1110, 7'h5E, 0, 8, 16'hBA2D, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 0, 0);
        vecs[15] = mk(4'b1011, 7'h39, 0, 8, 16'hBC2D, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vecs[16] = mk(4'b1101, 7'h7D, 0, 8, 16'hBC6D, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 0);

        reset = 1'b1;
        drive(4'b1111, 7'h00, 1'b0);
        repeat (3) tick();
        check("reset_outputs", {data, digit_valid, blank, minus, dp_out, frame_done, err, stale}, 64'd0);

        // Static digit 0: captured on the fifth sampled edge, then left alone until timeout.
        reset = 1'b0;
        drive(4'b1110, 7'h3F, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("static_pre_valid_t%0d", k), digit_valid, 4'b0000);
        end
        tick();
        check("static_valid", digit_valid, 4'b0001);
        check("static_data", data, 16'h0000);
        check("static_dp", dp_out, 4'b0000);
        for (int k = 6; k <= 68; k++) tick();
        check("static_no_recapture_stale_lo", stale, 1'b0);
        tick();
        check("static_timeout_stale_hi", stale, 1'b1);
        check("static_timeout_valid", digit_valid, 4'b0000);
        for (int k = 70; k <= 100; k++) tick();
        check("static_err_pulses", err_cnt, 0);
        check("static_frame_pulses", frame_cnt, 0);

        // Dwell table: expectation queued at drive time, compared at dwell end.
        for (int i = 0; i < 17; i++) begin
            f0 = frame_cnt;
            e0 = err_cnt;
            drive(vecs[i].an, vecs[i].p, vecs[i].dpon);
            exp_q.push_back(vecs[i]);
            repeat (vecs[i].hold) tick();
            e = exp_q.pop_front();
            check($sformatf("v%0d_data", i), data, e.data);
            check($sformatf("v%0d_valid", i), digit_valid, e.vld);
            check($sformatf("v%0d_blank", i), blank, e.blk);
            check($sformatf("v%0d_minus", i), minus, e.mns);
            check($sformatf("v%0d_dp", i), dp_out, e.dpo);
            check($sformatf("v%0d_stale", i), stale, 1'b0);
            check($sformatf("v%0d_frames", i), frame_cnt - f0, e.frames);
            check($sformatf("v%0d_errs", i), err_cnt - e0, e.errs);
        end

        // Reset on the third edge of a dwell; the full hold restarts afterwards.
        drive(4'b1110, 7'h06, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midreset_outputs", {data, digit_valid, blank, minus, dp_out, frame_done, err, stale}, 64'd0);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("midreset_pre_valid_t%0d", k), digit_valid, 4'b0000);
        end
        tick();
        check("midreset_valid", digit_valid, 4'b0001);
        check("midreset_data", data, 16'h0001);

        // Scan stops: stale exactly TIMEOUT edges after the last capture.
        drive(4'b1111, 7'h00, 1'b0);
        for (int k = 1; k <= 63; k++) tick();
        check("idle_stale_lo", stale, 1'b0);
        tick();
        check("idle_stale_hi", stale, 1'b1);
        check("idle_valid_cleared", digit_valid, 4'b0000);
        check("idle_data_held", data, 16'h0001);
        drive(4'b1101, 7'h4F, 1'b0);
        for (int k = 1; k <= 4; k++) tick();
        check("resume_stale_before", stale, 1'b1);
        tick();
        check("resume_stale_cleared", stale, 1'b0);
        check("resume_valid", digit_valid, 4'b0010);
        check("resume_data", data, 16'h0031);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sseg4_decoder.md
Name: sseg4_decoder

Overview:
- Receive-side counterpart of the 4-digit seven-segment driver (sseg4).
- Samples the multiplexed active-low anode, segment and decimal-point lines, waits for each digit dwell to be stable, and decodes the lit pattern back into a hex nibble with blank/minus/dp flags.
- Used for on-board loopback checking of the display path, and as a scoreboard front-end in display testbenches.

Parameters:
- STABLE_CYCLES, 4: consecutive cycles the sampled {an,seg,dp} must stay identical before a dwell is captured. Range 2..255.
- TIMEOUT_CYCLES, 1048576: cycles without any capture before all decoded digits are declared stale. Must be ≥ 4*STABLE_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- an  in  4  anode enables, active-low; an[0] = rightmost digit
- seg  in  7  segments, active-low; seg[0]=a … seg[6]=g
- dp  in  1  decimal point, active-low
- data  out  16  decoded nibbles; data[4i+3:4i] = digit i
- digit_valid  out  4  bit i = digit i last captured a recognised hex pattern
- blank  out  4  bit i = digit i last captured all segments off
- minus  out  4  bit i = digit i last captured only segment g lit
- dp_out  out  4  bit i = dp lit during digit i's last capture
- frame_done  out  1  one-cycle pulse when all four digits have been captured since the last pulse or reset
- err  out  1  one-cycle pulse on capture of an unrecognised segment pattern
- stale  out  1  high after TIMEOUT_CYCLES cycles with no capture

Behaviour:
- Reset (synchronous, active-high): all outputs 0. Stability counter, seen[3:0] and timeout counter cleared. Reset mid-dwell discards the progress; a full STABLE_CYCLES hold is required again after reset deasserts.
- Input stage: {an,seg,dp} registered once into r. Stability counter cnt:
  - r differs from its previous value: cnt ← 1.
  - r equal to its previous value: cnt increments, saturating at STABLE_CYCLES.
- Valid dwell: r.an has exactly one bit low. Any other anode value (all high, or 2+ low) is idle: cnt held at 0, no capture.
- Capture: fires exactly once per dwell, on the edge where cnt reaches STABLE_CYCLES with a valid anode. It re-fires only after r changes.
- Capture latency: a value present before edge 0 and held is reflected on the outputs after edge STABLE_CYCLES (edge 4 by default).
- Decode on capture for digit i, using active-high pattern p = ~seg in gfedcba order:
  - Hex table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - Table match: data nibble ← value; digit_valid[i]=1; blank[i]=0; minus[i]=0.
  - p=00: blank[i]=1; digit_valid[i]=0; minus[i]=0; nibble held.
  - p=40: minus[i]=1; digit_valid[i]=0; blank[i]=0; nibble held.
  - Any other p: digit_valid, blank and minus bits for i cleared; nibble held; err pulses on the cycle after the capture edge.
  - dp_out[i] ← ~dp on every capture, including the error case.
- Frame tracking:
  - Each capture sets seen[i].
  - When a capture makes seen all ones, frame_done pulses for one cycle after that edge and seen clears on the same edge.
  - Re-capturing an already-seen digit only updates that digit's outputs; it does not end the frame.
- Timeout:
  - Counter increments every cycle and resets to 0 on any capture.
  - When it reaches TIMEOUT_CYCLES: stale=1, digit_valid=0, seen=0. Data, blank, minus and dp_out are held.
  - The next capture clears stale.
  - A capture and a timeout on the same edge: capture wins; stale stays 0.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- Static digit: an=1110, seg=~3F, dp=1 held for 6 cycles → data[3:0]=0, digit_valid=0001, dp_out=0000, updated exactly on edge 4. Same value held 100 cycles → exactly one capture, err never pulses.
- Full scan at 8 cycles/digit of "1A2F" with dp on digit 2 → data=16'h1A2F, digit_valid=1111, dp_out=0100, frame_done one pulse per 4-digit scan.
- Glitch: 3-cycle dwell (< STABLE_CYCLES) on an=1101 → no capture, digit 1 unchanged. Anode 1100 held 10 cycles → no capture.
- Special patterns: digit 3 shows p=40, then p=00, then p=55 → minus=1000, then blank=1000, then err one pulse with digit_valid[3]=0 and data[15:12] held.
- Timeout with TIMEOUT_CYCLES=64: scan stops with an=1111 → stale=1 and digit_valid=0000 on cycle 64 after the last capture. A new valid dwell clears stale.
- Reset asserted on cycle 2 of a dwell, then released → all outputs 0, and the capture needs 4 further stable cycles after release.
